// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// A captured WIDTH-bit value is shifted into a five-digit BCD
// accumulator one bit per cycle. The digits and sign are registered
// once at the end, so the outputs never show partial results.
// Optional build macro: BIN2BCD_SIGNED_EN treats bin as two's complement,
// converts its magnitude and reports the sign; otherwise bin is unsigned
// and sign is tied to 0.
module bin2bcd_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [3:0]       dig4,
  output logic [3:0]       dig3,
  output logic [3:0]       dig2,
  output logic [3:0]       dig1,
  output logic [3:0]       dig0
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [4:0]          cnt;
  logic [19:0]         acc;
  logic [19:0]         acc_adj;
  logic [WIDTH-1:0]    shreg;
  logic [WIDTH-1:0]    mag;
  logic [20+WIDTH-1:0] shifted;
  logic                accept;

  // The done cycle is already IDLE, so a start seen alongside done
  // is refused here; the next IDLE cycle with start is honoured.
  assign accept = (state == IDLE) && start && !done;
  assign busy   = (state != IDLE);

`ifdef BIN2BCD_SIGNED_EN
  logic neg;

  // Two's complement magnitude; the most negative value maps onto
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  assign mag = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;

  // Remember the sign at capture and publish it together with the digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg  <= 1'b0;
      sign <= 1'b0;
    end else begin
      if (accept)
        neg <= bin[WIDTH-1];
      if (state == DONE)
        sign <= neg;
    end
  end
`else
  assign mag  = bin;
  assign sign = 1'b0;
`endif

  // Add 3 to every BCD digit of 5 or more before the next shift
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // The binary MSB enters the accumulator LSB as the pair shifts left
  assign shifted = {acc_adj, shreg} << 1;

  // Sequencer: capture, WIDTH shift steps, then publish the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
      acc   <= 20'd0;
      shreg <= '0;
      done  <= 1'b0;
      dig4  <= 4'd0;
      dig3  <= 4'd0;
      dig2  <= 4'd0;
      dig1  <= 4'd0;
      dig0  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= 20'd0;
            shreg <= mag;
            cnt   <= 5'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= shifted[20+WIDTH-1:WIDTH];
          shreg <= shifted[WIDTH-1:0];
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1)
            state <= DONE;
        end
        DONE: begin
          dig4  <= acc[19:16];
          dig3  <= acc[15:12];
          dig2  <= acc[11:8];
          dig1  <= acc[7:4];
          dig0  <= acc[3:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
